// File: rtl/j_acc_serializer_mx_pkg.sv
// j_acc_pkg: shared constants, FSM state type and clog2 helper for the
// accumulator serializer (j_acc_serializer_mx and its lane sub-module).
// Optional feature macro used by the design: J_ACC_SER_CLEAR_EN.
package j_acc_pkg;

  localparam int ACC_LANES      = 32;
  localparam int ACC_WORD_W     = 32;
  localparam int SRAM_DEPTH_DEF = 256 * 256 * 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Ceiling log2; valid for depths up to 2^62.
  function automatic int clog2(input longint value);
    int res;
    res = 0;
    for (int i = 0; i < 62; i++) begin
      if ((longint'(1) << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/j_acc_serializer_mx_if.sv
// j_acc_serializer_mx_if: job control, SRAM read port and serial lane
// outputs of the accumulator serializer bundled into one interface.
// The slave modport is the serializer's view, master is the driver's view.
// With J_ACC_SER_CLEAR_EN defined the interface carries clear_mode.
interface j_acc_serializer_mx_if #(
  parameter int ADDR_W = j_acc_pkg::clog2(j_acc_pkg::SRAM_DEPTH_DEF)
);
  import j_acc_pkg::*;

  logic                        start;
  logic [ADDR_W*ACC_LANES-1:0] start_addr;
  logic [ADDR_W-1:0]           img_size;
  logic                        sram_en;
  logic [ADDR_W-1:0]           sram_addr;
  logic [ACC_WORD_W-1:0]       sram_rdata;
  logic [ACC_LANES-1:0]        serial_out;
  logic [ACC_LANES-1:0]        serial_en;
  logic                        busy;
  logic                        done;

`ifdef J_ACC_SER_CLEAR_EN
  logic                        clear_mode;

  modport slave (
    input  start, start_addr, img_size, clear_mode, sram_rdata,
    output sram_en, sram_addr, serial_out, serial_en, busy, done
  );

  modport master (
    output start, start_addr, img_size, clear_mode, sram_rdata,
    input  sram_en, sram_addr, serial_out, serial_en, busy, done
  );
`else
  modport slave (
    input  start, start_addr, img_size, sram_rdata,
    output sram_en, sram_addr, serial_out, serial_en, busy, done
  );

  modport master (
    output start, start_addr, img_size, sram_rdata,
    input  sram_en, sram_addr, serial_out, serial_en, busy, done
  );
`endif

endinterface

// File: rtl/j_acc_serializer_mx_lane.sv
// j_acc_ser_lane: one serializer lane. Holds a word in a right-shifting
// register and counts the bits still to be presented; serial_en is high
// while bits remain. A load arriving as the last bit leaves keeps the
// stream gap-free across consecutive words.
module j_acc_ser_lane
  import j_acc_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ACC_WORD_W-1:0] load_data,
  output logic                  serial_out,
  output logic                  serial_en
);

  localparam int CNT_W = clog2(ACC_WORD_W + 1);

  logic [ACC_WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Load a fresh word, otherwise shift out one bit per cycle while bits remain.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      shreg_d = load_data;
      cnt_d   = CNT_W'(ACC_WORD_W);
    end else if (cnt_q != '0) begin
      shreg_d = shreg_q >> 1;
      cnt_d   = cnt_q - CNT_W'(1);
    end
  end

  // Shift register and remaining-bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign serial_en  = (cnt_q != '0);
  assign serial_out = serial_en & shreg_q[0];

endmodule

// File: rtl/j_acc_serializer_mx.sv
// j_acc_serializer_mx: reads 32-bit partial sums for 32 lanes through one
// shared SRAM read port (one read per cycle, lane = phase, round-robin)
// and streams each word LSB-first on that lane's serial output. Lane i
// runs one cycle behind lane i-1, so the read slots never collide.
// Optional feature macro: J_ACC_SER_CLEAR_EN (adds clear_mode: the job
// streams zeros without touching the SRAM).
module j_acc_serializer_mx
  import j_acc_pkg::*;
#(
  parameter int SRAM_DEPTH  = SRAM_DEPTH_DEF,
  parameter int SRAM_ADDR_W = clog2(SRAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  j_acc_serializer_mx_if.slave bus
);

  localparam int AW   = SRAM_ADDR_W;
  localparam int PH_W = clog2(ACC_LANES);
  localparam int DR_W = clog2(ACC_WORD_W + 1);
  localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(ACC_LANES - 1);
  // Last load lands one cycle after the final read, then 32 bits follow.
  localparam logic [DR_W-1:0] DRAIN_LAST = DR_W'(ACC_WORD_W);

  state_t                state_q, state_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [AW-1:0]         k_q, k_d;
  logic [AW-1:0]         n_q, n_d;
  logic [AW-1:0]         base_q [ACC_LANES];
  logic [AW-1:0]         base_d [ACC_LANES];
  logic [DR_W-1:0]       drain_q, drain_d;
  logic                  done_q, done_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [PH_W-1:0]       rd_lane_q, rd_lane_d;
  logic                  clear_active;
  logic                  sram_en;
  logic [ACC_WORD_W-1:0] load_word;
  logic [ACC_LANES-1:0]  lane_out;
  logic [ACC_LANES-1:0]  lane_en;

`ifdef J_ACC_SER_CLEAR_EN
  logic clear_q, clear_d;

  // Clear-mode flag is captured together with the other job parameters.
  always_comb begin
    clear_d = clear_q;
    if ((state_q == IDLE) && bus.start) begin
      clear_d = bus.clear_mode;
    end
  end

  // Clear-mode flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clear_q <= 1'b0;
    end else begin
      clear_q <= clear_d;
    end
  end

  assign clear_active = clear_q;
`else
  assign clear_active = 1'b0;
`endif

  // Job FSM: latch parameters on start, walk phase/k during RUN, then
  // wait out the tail of lane 31 in DRAIN before pulsing done.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    k_d     = k_q;
    n_d     = n_q;
    base_d  = base_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < ACC_LANES; i++) begin
            base_d[i] = bus.start_addr[i*AW +: AW];
          end
          n_d     = bus.img_size;
          phase_d = '0;
          k_d     = '0;
          drain_d = '0;
          if (bus.img_size != '0) begin
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        phase_d = phase_q + PH_W'(1);
        if (phase_q == LAST_PHASE) begin
          if (k_q == n_q - AW'(1)) begin
            state_d = DRAIN;
            drain_d = '0;
          end else begin
            k_d = k_q + AW'(1);
          end
        end
      end
      DRAIN: begin
        drain_d = drain_q + DR_W'(1);
        if (drain_q == DRAIN_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read pipeline: remember which lane each RUN slot belongs to so the
  // returning data (one cycle later) lands in the right shift register.
  always_comb begin
    rd_valid_d = (state_q == RUN);
    rd_lane_d  = phase_q;
  end

  // State, counters, latched job parameters and pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      k_q        <= '0;
      n_q        <= '0;
      drain_q    <= '0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_lane_q  <= '0;
      for (int i = 0; i < ACC_LANES; i++) begin
        base_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      k_q        <= k_d;
      n_q        <= n_d;
      drain_q    <= drain_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_lane_q  <= rd_lane_d;
      for (int i = 0; i < ACC_LANES; i++) begin
        base_q[i] <= base_d[i];
      end
    end
  end

  // Address wraps modulo 2^AW by construction of the AW-bit sum.
  assign sram_en       = (state_q == RUN) && !clear_active;
  assign bus.sram_en   = sram_en;
  assign bus.sram_addr = sram_en ? (base_q[phase_q] + k_q) : '0;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign load_word     = clear_active ? '0 : bus.sram_rdata;

  genvar gi;
  generate
    for (gi = 0; gi < ACC_LANES; gi++) begin : g_lane
      logic lane_load;
      assign lane_load = rd_valid_q && (rd_lane_q == PH_W'(gi));

      j_acc_ser_lane u_lane (
        .clk        (clk),
        .reset      (reset),
        .load       (lane_load),
        .load_data  (load_word),
        .serial_out (lane_out[gi]),
        .serial_en  (lane_en[gi])
      );
    end
  endgenerate

  assign bus.serial_out = lane_out;
  assign bus.serial_en  = lane_en;

endmodule

// File: tb/tb_j_acc_serializer_mx.sv
// tb_j_acc_serializer_mx: self-checking bench for j_acc_serializer_mx.
// Expected behaviour comes from closed-form timing: lane i word k is read
// in cycle S+1+32k+i and bit b of it is shown in cycle S+3+i+32k+b.
// Build with J_ACC_SER_CLEAR_EN defined to include the clear-mode test.
`timescale 1ns/1ps
module tb_j_acc_serializer_mx;
  import j_acc_pkg::*;

  localparam int AW    = clog2(SRAM_DEPTH_DEF);
  localparam int LANES = ACC_LANES;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  j_acc_serializer_mx_if #(.ADDR_W(AW)) bus ();

  j_acc_serializer_mx #(
    .SRAM_DEPTH  (SRAM_DEPTH_DEF),
    .SRAM_ADDR_W (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Job description used by the reference model.
  logic [AW-1:0] job_base [LANES];
  int            job_n;
  int            job_mode;
  logic          job_clear;
  logic [31:0]   job_seed;

  logic [AW+2:0]    got_ctrl, exp_ctrl;
  logic [LANES-1:0] got_sen, exp_sen, got_sout, exp_sout;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] aw;
    aw = 32'(a);
    case (job_mode)
      0:       return 32'hA500_0000 | aw;
      1:       return aw + 32'd1;
      default: return (aw * 32'h9E37_79B1) ^ job_seed;
    endcase
  endfunction

  // Registered-read SRAM model; returns junk when not enabled.
  always @(posedge clk) begin
    if (bus.sram_en) bus.sram_rdata <= mem_word(bus.sram_addr);
    else             bus.sram_rdata <= $urandom();
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got=running want=finished");
    $fatal(1, "watchdog");
  end

  // Wait to mid-cycle S+rel, capture DUT outputs and the model's view.
  task automatic sample_cycle(input int rel);
    int n32, j, r;
    logic [31:0] w;
    logic [AW-1:0] e_addr;
    logic e_busy, e_done, e_en;
    @(negedge clk);
    got_ctrl = {bus.busy, bus.done, bus.sram_en, bus.sram_addr};
    got_sen  = bus.serial_en;
    got_sout = bus.serial_out;
    n32    = 32 * job_n;
    e_busy = (job_n != 0) && (rel >= 1) && (rel <= n32 + 33);
    e_done = (job_n == 0) ? (rel == 1) : (rel == n32 + 34);
    e_en   = !job_clear && (rel >= 1) && (rel <= n32);
    e_addr = '0;
    if (e_en) begin
      j = rel - 1;
      e_addr = job_base[j % LANES] + AW'(j / LANES);
    end
    exp_ctrl = {e_busy, e_done, e_en, e_addr};
    exp_sen  = '0;
    exp_sout = '0;
    for (int i = 0; i < LANES; i++) begin
      r = rel - 3 - i;
      if (r >= 0 && r < n32) begin
        exp_sen[i] = 1'b1;
        w = job_clear ? 32'h0 : mem_word(job_base[i] + AW'(r / 32));
        exp_sout[i] = w[r % 32];
      end
    end
  endtask

  task automatic start_job(input string tag);
    for (int i = 0; i < LANES; i++) bus.start_addr[i*AW +: AW] = job_base[i];
    bus.img_size = AW'(job_n);
`ifdef J_ACC_SER_CLEAR_EN
    bus.clear_mode = job_clear;
`endif
    bus.start = 1'b1;
    $display("job %s: N=%0d mode=%0d clear=%0b base0=%0h", tag, job_n, job_mode, job_clear, job_base[0]);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < LANES; i++) bus.start_addr[i*AW +: AW] = AW'($urandom());
    bus.img_size = AW'($urandom());
  endtask

  task automatic setup_sc1();
    for (int i = 0; i < LANES; i++) job_base[i] = AW'(16 * i);
    job_n = 1; job_mode = 0; job_clear = 1'b0;
  endtask

  task automatic setup_random(input int n);
    for (int i = 0; i < LANES; i++) job_base[i] = AW'($urandom());
    job_n = n; job_mode = 2; job_clear = 1'b0; job_seed = $urandom();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.start_addr = '0; bus.img_size = '0;
`ifdef J_ACC_SER_CLEAR_EN
    bus.clear_mode = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.sram_en, bus.sram_addr, bus.serial_en, bus.serial_out} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got busy=%b done=%b en=%b addr=%h sen=%h sout=%h want all 0",
               bus.busy, bus.done, bus.sram_en, bus.sram_addr, bus.serial_en, bus.serial_out);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.sram_en, bus.serial_en} !== '0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b en=%b sen=%h want all 0",
               bus.busy, bus.done, bus.sram_en, bus.serial_en);
    end
  endtask

  task automatic test_single_word();
    setup_sc1();
    start_job("single_word");
    for (int rel = 1; rel <= 32 * job_n + 35; rel++) begin
      sample_cycle(rel);
      checks++; if (got_ctrl !== exp_ctrl) begin errors++; $display("FAIL sc1_ctrl rel=%0d got=%h want=%h", rel, got_ctrl, exp_ctrl); end
      checks++; if (got_sen !== exp_sen) begin errors++; $display("FAIL sc1_sen rel=%0d got=%h want=%h", rel, got_sen, exp_sen); end
      checks++; if (got_sout !== exp_sout) begin errors++; $display("FAIL sc1_sout rel=%0d got=%h want=%h", rel, got_sout, exp_sout); end
    end
  endtask

  task automatic test_multi_word();
    int first5, cnt5;
    first5 = -1; cnt5 = 0;
    for (int i = 0; i < LANES; i++) job_base[i] = '0;
    job_n = 3; job_mode = 1; job_clear = 1'b0;
    start_job("multi_word");
    for (int rel = 1; rel <= 32 * job_n + 35; rel++) begin
      sample_cycle(rel);
      if (got_sen[5] && first5 < 0) first5 = rel;
      if (got_sen[5]) cnt5++;
      checks++; if (got_ctrl !== exp_ctrl) begin errors++; $display("FAIL sc2_ctrl rel=%0d got=%h want=%h", rel, got_ctrl, exp_ctrl); end
      checks++; if (got_sen !== exp_sen) begin errors++; $display("FAIL sc2_sen rel=%0d got=%h want=%h", rel, got_sen, exp_sen); end
      checks++; if (got_sout !== exp_sout) begin errors++; $display("FAIL sc2_sout rel=%0d got=%h want=%h", rel, got_sout, exp_sout); end
    end
    checks++;
    if (first5 != 8 || cnt5 != 96) begin
      errors++;
      $display("FAIL sc2_lane5_run: got start=S+%0d len=%0d want start=S+8 len=96", first5, cnt5);
    end
  endtask

  task automatic test_zero_len();
    setup_random(0);
    start_job("zero_len");
    for (int rel = 1; rel <= 4; rel++) begin
      sample_cycle(rel);
      checks++; if (got_ctrl !== exp_ctrl) begin errors++; $display("FAIL sc3_ctrl rel=%0d got=%h want=%h", rel, got_ctrl, exp_ctrl); end
      checks++; if (got_sen !== exp_sen) begin errors++; $display("FAIL sc3_sen rel=%0d got=%h want=%h", rel, got_sen, exp_sen); end
    end
  endtask

  task automatic test_addr_wrap();
    setup_random(2);
    job_base[0] = '1;
    start_job("addr_wrap");
    for (int rel = 1; rel <= 32 * job_n + 35; rel++) begin
      sample_cycle(rel);
      checks++; if (got_ctrl !== exp_ctrl) begin errors++; $display("FAIL sc4_ctrl rel=%0d got=%h want=%h", rel, got_ctrl, exp_ctrl); end
      checks++; if (got_sen !== exp_sen) begin errors++; $display("FAIL sc4_sen rel=%0d got=%h want=%h", rel, got_sen, exp_sen); end
      checks++; if (got_sout !== exp_sout) begin errors++; $display("FAIL sc4_sout rel=%0d got=%h want=%h", rel, got_sout, exp_sout); end
    end
  endtask

  task automatic test_reset_abort();
    setup_sc1();
    start_job("reset_abort");
    for (int rel = 1; rel <= 40; rel++) begin
      sample_cycle(rel);
      checks++; if (got_ctrl !== exp_ctrl) begin errors++; $display("FAIL sc5_ctrl rel=%0d got=%h want=%h", rel, got_ctrl, exp_ctrl); end
      checks++; if (got_sout !== exp_sout) begin errors++; $display("FAIL sc5_sout rel=%0d got=%h want=%h", rel, got_sout, exp_sout); end
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.sram_en, bus.sram_addr} !== '0) begin
      errors++;
      $display("FAIL sc5_async_ctrl: got busy=%b done=%b en=%b addr=%h want 0", bus.busy, bus.done, bus.sram_en, bus.sram_addr);
    end
    checks++;
    if ({bus.serial_en, bus.serial_out} !== '0) begin
      errors++;
      $display("FAIL sc5_async_serial: got sen=%h sout=%h want 0", bus.serial_en, bus.serial_out);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.sram_en, bus.serial_en} !== '0) begin
        errors++;
        $display("FAIL sc5_no_done c=%0d: got busy=%b done=%b en=%b sen=%h want 0", c, bus.busy, bus.done, bus.sram_en, bus.serial_en);
      end
    end
    test_single_word();
  endtask

  task automatic test_start_ignored();
    setup_random(2);
    start_job("start_ignored");
    for (int rel = 1; rel <= 32 * job_n + 35; rel++) begin
      sample_cycle(rel);
      checks++; if (got_ctrl !== exp_ctrl) begin errors++; $display("FAIL sc6_ctrl rel=%0d got=%h want=%h", rel, got_ctrl, exp_ctrl); end
      checks++; if (got_sen !== exp_sen) begin errors++; $display("FAIL sc6_sen rel=%0d got=%h want=%h", rel, got_sen, exp_sen); end
      checks++; if (got_sout !== exp_sout) begin errors++; $display("FAIL sc6_sout rel=%0d got=%h want=%h", rel, got_sout, exp_sout); end
      if (rel == 20 || rel == 50) begin
        bus.img_size = AW'(5);
        bus.start    = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_back_to_back();
    setup_sc1();
    start_job("b2b_first");
    for (int rel = 1; rel <= 32 * job_n + 34; rel++) begin
      sample_cycle(rel);
      checks++; if (got_ctrl !== exp_ctrl) begin errors++; $display("FAIL b2b_a_ctrl rel=%0d got=%h want=%h", rel, got_ctrl, exp_ctrl); end
      checks++; if (got_sout !== exp_sout) begin errors++; $display("FAIL b2b_a_sout rel=%0d got=%h want=%h", rel, got_sout, exp_sout); end
    end
    setup_random(2);
    start_job("b2b_second");
    for (int rel = 1; rel <= 32 * job_n + 35; rel++) begin
      sample_cycle(rel);
      checks++; if (got_ctrl !== exp_ctrl) begin errors++; $display("FAIL b2b_b_ctrl rel=%0d got=%h want=%h", rel, got_ctrl, exp_ctrl); end
      checks++; if (got_sen !== exp_sen) begin errors++; $display("FAIL b2b_b_sen rel=%0d got=%h want=%h", rel, got_sen, exp_sen); end
      checks++; if (got_sout !== exp_sout) begin errors++; $display("FAIL b2b_b_sout rel=%0d got=%h want=%h", rel, got_sout, exp_sout); end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 3; t++) begin
      setup_random($urandom_range(1, 3));
      start_job("random");
      for (int rel = 1; rel <= 32 * job_n + 35; rel++) begin
        sample_cycle(rel);
        checks++; if (got_ctrl !== exp_ctrl) begin errors++; $display("FAIL rnd_ctrl t=%0d rel=%0d got=%h want=%h", t, rel, got_ctrl, exp_ctrl); end
        checks++; if (got_sen !== exp_sen) begin errors++; $display("FAIL rnd_sen t=%0d rel=%0d got=%h want=%h", t, rel, got_sen, exp_sen); end
        checks++; if (got_sout !== exp_sout) begin errors++; $display("FAIL rnd_sout t=%0d rel=%0d got=%h want=%h", t, rel, got_sout, exp_sout); end
      end
    end
  endtask

`ifdef J_ACC_SER_CLEAR_EN
  task automatic test_clear();
    setup_random(2);
    job_clear = 1'b1;
    start_job("clear");
    for (int rel = 1; rel <= 32 * job_n + 35; rel++) begin
      sample_cycle(rel);
      checks++; if (got_ctrl !== exp_ctrl) begin errors++; $display("FAIL clr_ctrl rel=%0d got=%h want=%h", rel, got_ctrl, exp_ctrl); end
      checks++; if (got_sen !== exp_sen) begin errors++; $display("FAIL clr_sen rel=%0d got=%h want=%h", rel, got_sen, exp_sen); end
      checks++; if (got_sout !== exp_sout) begin errors++; $display("FAIL clr_sout rel=%0d got=%h want=%h", rel, got_sout, exp_sout); end
    end
    job_clear = 1'b0;
  endtask
`endif

  initial begin
    job_clear = 1'b0;
    job_seed  = 32'h1234_5678;
    job_mode  = 0;
    job_n     = 0;
    test_reset();
    test_single_word();
    test_multi_word();
    test_zero_len();
    test_addr_wrap();
    test_reset_abort();
    test_start_ignored();
    test_back_to_back();
    test_random();
`ifdef J_ACC_SER_CLEAR_EN
    test_clear();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/j_acc_serializer_mx.md
Name: j_acc_serializer_mx

Overview:
Upstream feeder for the 32-lane accumulator deshifter array. It reads 32-bit partial sums for 32 lanes from one shared single-port SRAM read port and turns them into 32 LSB-first bit-serial streams (serial_out/serial_en). Lane i is skewed one cycle behind lane i-1, matching the deshifter's staggered start. Because of the skew, the single read port is time-division multiplexed with one read per cycle and no conflicts.

Parameters:
SRAM_DEPTH, 256*256*4, words in the accumulator SRAM.
SRAM_ADDR_W, clog2(SRAM_DEPTH), SRAM address width.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle start pulse; sampled only in IDLE.
start_addr  in  SRAM_ADDR_W*32  per-lane base address; lane i at [i*SRAM_ADDR_W +: SRAM_ADDR_W].
img_size  in  SRAM_ADDR_W  words per lane (N).
sram_en  out  1  read enable.
sram_addr  out  SRAM_ADDR_W  read address.
sram_rdata  in  32  read data, valid exactly 1 cycle after sram_en.
serial_out  out  32  per-lane serial bit.
serial_en  out  32  per-lane bit-valid.
busy  out  1  high in RUN/DRAIN.
done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset values: all outputs are 0. The FSM is in IDLE, and all counters and shift registers are cleared. Reset is asynchronous and aborts any job mid-flight; no done pulse is produced for an aborted job.
- FSM states: IDLE, RUN, DRAIN.
- Start in IDLE (start=1 at edge S):
  - latch all start_addr and img_size values;
  - phase=0, k=0;
  - if N!=0, go to RUN; if N==0, go to IDLE with done=1 in cycle S+1 and no reads.
- start is ignored while busy.
- RUN, each cycle:
  - sram_en=1, sram_addr=base[phase]+k, truncated modulo 2^SRAM_ADDR_W (wrap permitted);
  - phase increments 0..31; when it wraps 31->0, k increments;
  - after the read with phase=31 and k=N-1, go to DRAIN.
  - The first read (lane 0, k=0) occurs in cycle S+1. The last read occurs in cycle S+32N.
- Read pipeline:
  - read issued in cycle t for lane p;
  - sram_rdata captured into lane p's 32-bit shift register at the end of cycle t+1 (the lane index is delayed 1 cycle alongside);
  - bits b=0..31 presented on serial_out[p] with serial_en[p]=1 in cycles t+2+b.
  - The shift register shifts right each cycle. The next load lands exactly as bit 31 is consumed, so each lane streams gap-free across words.
- Lane timing: lane i word k is serialized in cycles S+3+i+32k .. S+34+i+32k.
- serial_en[i] falls after lane i's last bit. serial_out is 0 whenever serial_en is 0.
- DRAIN: a counter waits until the last bit of lane 31 (cycle S+32N+33). Then done=1 and the FSM returns to IDLE at edge S+32N+34.
- busy=1 from S+1 through S+32N+33 inclusive.
- A new start is accepted in the cycle done is high.

Optional Feature:
Macro J_ACC_SER_CLEAR_EN.
- Defined: adds input clear_mode (1 bit), latched at start. When the latched value is 1:
  - sram_en stays 0 for the whole job;
  - lanes load 32'h0 in their slot;
  - serial_en timing and done timing are identical to a normal job (zero-init first accumulation pass).
- Undefined: no clear_mode port, and reads always occur.

Decomposition:
- Package j_acc_pkg: localparams ACC_LANES=32 and ACC_WORD_W=32, the FSM state enum (IDLE/RUN/DRAIN), and the clog2 function.
- One sub-module: j_acc_ser_lane, containing the 32-bit load/shift register plus the serial_en bit counter. It is instantiated 32 times by generate.
- The TDM FSM, address generation and read-pipeline registers stay in the top.

Test Plan:
1. N=1, start_addr[i]=16*i, mem[a]=32'hA5000000|a, start at S=10:
   - sram_addr equals 16*i in cycle 11+i;
   - lane 0 serializes 32'hA5000000 LSB-first in cycles 13..44;
   - lane 31 serializes 32'hA50001F0 in cycles 44..75;
   - done pulses in cycle 76.
2. N=3, base 0 for all lanes, mem[a]=a+1:
   - lane 5 words 1,2,3 appear back-to-back with serial_en continuous for 96 cycles starting at S+8.
3. N=0:
   - no sram_en;
   - done in cycle S+1;
   - busy stays 0.
4. start_addr[0]=2^SRAM_ADDR_W-1, N=2:
   - lane 0 reads that address, then address 0 (wrap).
5. Reset asserted mid-RUN at cycle S+40:
   - all outputs go 0 immediately;
   - no done pulse;
   - a fresh start then behaves as in scenario 1.
6. start pulsed again while busy is ignored. With J_ACC_SER_CLEAR_EN and clear_mode=1, N=2:
   - zero sram_en;
   - all serial_out are 0;
   - serial_en and done timing equal scenario 2's pattern for N=2.
